// File: rtl/program_mem_ctrl_pkg.sv
// Types shared between the program-memory responder and its request FIFO.
`include "define.sv"

package program_mem_ctrl_pkg;

   // Source of the single array access performed at an edge (loads pre-empt both).
   typedef enum logic [1:0] {
      ISSUE_NONE,
      ISSUE_FIFO,
      ISSUE_BYPASS
   } issue_src_e;

endpackage

// File: rtl/define.sv
// Project-wide program-memory geometry shared by sm_core and program_mem_ctrl.
`ifndef PROGRAM_MEM_DEFINE_SV
`define PROGRAM_MEM_DEFINE_SV

`define PROGRAM_MEM_ADDR_BITS 8
`define PROGRAM_MEM_DATA_BITS 32
`define PROGRAM_MEM_READ_LATENCY 2

`endif

// File: rtl/req_fifo.sv
// Synchronous request FIFO; dout_o is the combinational head entry.
module req_fifo
   import program_mem_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/program_mem_ctrl.sv
// Program-memory responder: single-port instruction array, request FIFO and
// fixed-latency read pipeline returning fetches in acceptance order.
`include "define.sv"

module program_mem_ctrl
   import program_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = `PROGRAM_MEM_ADDR_BITS,
   parameter int unsigned DATA_BITS    = `PROGRAM_MEM_DATA_BITS,
   parameter int unsigned READ_LATENCY = `PROGRAM_MEM_READ_LATENCY,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 program_mem_available_o,
   input  logic                 program_read_valid_i,
   input  logic [ADDR_BITS-1:0] program_read_addr_i,
   output logic                 program_read_ready_o,
   output logic [DATA_BITS-1:0] program_read_data_o,
   input  logic                 load_valid_i,
   input  logic [ADDR_BITS-1:0] load_addr_i,
   input  logic [DATA_BITS-1:0] load_data_i,
   output logic                 busy_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_BITS-1:0]    mem_q [2**ADDR_BITS];

   logic                    accept;
   logic                    fifo_push, fifo_pop;
   logic                    fifo_full, fifo_empty;
   logic [ADDR_BITS-1:0]    fifo_head;
   logic [ADDR_BITS-1:0]    issue_addr;
   logic [CNT_W-1:0]        fifo_count;
   issue_src_e              issue_src;

   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_BITS-1:0]    data_q [READ_LATENCY];
   logic [DATA_BITS-1:0]    data_d [READ_LATENCY];

   assign program_mem_available_o = !fifo_full;

   req_fifo #(
      .WIDTH (ADDR_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (program_read_addr_i),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // One array access per edge: load write, else queued head, else the new fetch.
   always_comb begin
      accept    = program_read_valid_i && program_mem_available_o;
      issue_src = ISSUE_NONE;
      if (!load_valid_i) begin
         if (!fifo_empty) begin
            issue_src = ISSUE_FIFO;
         end else if (accept) begin
            issue_src = ISSUE_BYPASS;
         end
      end
      fifo_push  = accept && (issue_src != ISSUE_BYPASS);
      fifo_pop   = (issue_src == ISSUE_FIFO);
      issue_addr = (issue_src == ISSUE_FIFO) ? fifo_head : program_read_addr_i;
   end

   // Data stages only advance behind a valid bit so the output word holds between pulses.
   always_comb begin
      vld_d     = '0;
      data_d    = data_q;
      vld_d[0]  = (issue_src != ISSUE_NONE);
      data_d[0] = vld_d[0] ? mem_q[issue_addr] : data_q[0];
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
         vld_d[s]  = vld_q[s-1];
         data_d[s] = vld_q[s-1] ? data_q[s-1] : data_q[s];
      end
   end

   always_ff @(posedge clk) begin
      if (load_valid_i) begin
         mem_q[load_addr_i] <= load_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         data_q <= '{default: '0};
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign program_read_ready_o = vld_q[READ_LATENCY-1];
   assign program_read_data_o  = data_q[READ_LATENCY-1];
   assign busy_o               = (fifo_count != '0) || (|vld_q);

endmodule

// File: tb/tb_program_mem_ctrl.sv
// Directed scoreboard bench for program_mem_ctrl at READ_LATENCY 1, 2 and 4 in lockstep.
module tb_program_mem_ctrl;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;
   localparam int LAT [3] = '{1, 2, 4};

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          rd_valid = 1'b0;
   logic [AW-1:0] rd_addr  = '0;
   logic          ld_valid = 1'b0;
   logic [AW-1:0] ld_addr  = '0;
   logic [DW-1:0] ld_data  = '0;

   logic [2:0]    avail, rdy, busy;
   logic [DW-1:0] rdata [3];

   int            cyc    = 0;
   int            n_vec  = 0;
   int            n_miss = 0;

   logic [DW-1:0] model [256];
   logic [DW-1:0] exp_data [$];
   int            exp_cyc [$];
   int            rd_idx [3] = '{0, 0, 0};
   bit            no_pulse_win = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      program_mem_ctrl #(
         .ADDR_BITS    (AW),
         .DATA_BITS    (DW),
         .READ_LATENCY (LAT[g]),
         .FIFO_DEPTH   (4)
      ) u_dut (
         .clk                     (clk),
         .rst_n                   (rst_n),
         .program_mem_available_o (avail[g]),
         .program_read_valid_i    (rd_valid),
         .program_read_addr_i     (rd_addr),
         .program_read_ready_o    (rdy[g]),
         .program_read_data_o     (rdata[g]),
         .load_valid_i            (ld_valid),
         .load_addr_i             (ld_addr),
         .load_data_i             (ld_data),
         .busy_o                  (busy[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Samples responses on the falling edge, then advances to 1 time unit past the next rising edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            chk($sformatf("rdy_in_reset_l%0d", LAT[i]), 32'(rdy[i]), 32'd0);
            rd_idx[i] = exp_data.size();
         end else if (rdy[i]) begin
            if (no_pulse_win)
               chk($sformatf("pulse_during_load_l%0d", LAT[i]), 32'(rdy[i]), 32'd0);
            if (rd_idx[i] >= int'(exp_data.size())) begin
               chk($sformatf("unexpected_pulse_l%0d", LAT[i]), 32'(rdy[i]), 32'd0);
            end else begin
               chk($sformatf("rdata_l%0d_n%0d", LAT[i], rd_idx[i]), 32'(rdata[i]),
                   32'(exp_data[rd_idx[i]]));
               if (exp_cyc[rd_idx[i]] >= 0)
                  chk($sformatf("ready_cycle_l%0d_n%0d", LAT[i], rd_idx[i]), cyc,
                      exp_cyc[rd_idx[i]] + LAT[i] - 1);
               rd_idx[i]++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      model[a] = d;
      tick();
      ld_valid = 1'b0;
   endtask

   // delay: edges from acceptance to issue, or -1 when the issue edge is not checked.
   task automatic fetch(input logic [AW-1:0] a, input int delay, output int waits);
      logic acc;
      bit   done;
      done     = 1'b0;
      waits    = 0;
      rd_valid = 1'b1;
      rd_addr  = a;
      while (!done) begin
         acc = avail[0];
         tick();
         if (acc) begin
            exp_data.push_back(model[a]);
            exp_cyc.push_back((delay < 0) ? -1 : cyc + delay);
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 40) begin
               chk("accept_timeout", waits, 0);
               done = 1'b1;
            end
         end
      end
      rd_valid = 1'b0;
   endtask

   function automatic bit all_done();
      bit r;
      r = 1'b1;
      for (int i = 0; i < 3; i++)
         if (rd_idx[i] != int'(exp_data.size())) r = 1'b0;
      return r;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (n < 60 && !all_done()) begin
         tick();
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain_count_l%0d", LAT[i]), rd_idx[i], exp_data.size());
         chk($sformatf("drain_busy_l%0d", LAT[i]), 32'(busy[i]), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_avail_l%0d", tag, LAT[i]), 32'(avail[i]), 32'd1);
         chk($sformatf("%s_rdy_l%0d", tag, LAT[i]), 32'(rdy[i]), 32'd0);
         chk($sformatf("%s_data_l%0d", tag, LAT[i]), 32'(rdata[i]), 32'd0);
         chk($sformatf("%s_busy_l%0d", tag, LAT[i]), 32'(busy[i]), 32'd0);
      end
   endtask

   initial begin
      int   w;
      int   n;
      logic acc;

      repeat (2) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single fetch with busy tail
      load(8'h10, 16'hA5A5);
      repeat (2) tick();
      fetch(8'h10, 0, w);
      chk("single_wait", w, 0);
      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("busy_tail_l%0d_j%0d", LAT[i], j), 32'(busy[i]), 32'(j < LAT[i]));
         tick();
      end
      drain();

      // Streaming back-to-back fetches
      for (int a = 0; a < 4; a++) load(AW'(a), DW'(16'h1000 + a));
      for (int a = 0; a < 4; a++) begin
         fetch(AW'(a), 0, w);
         chk("stream_wait", w, 0);
      end
      drain();

      // FIFO fills behind 8 load edges
      for (int a = 0; a < 6; a++) load(AW'(8'h40 + a), DW'(16'h4000 + a));
      no_pulse_win = 1'b1;
      n = 0;
      ld_valid = 1'b1;
      for (int e = 0; e < 8; e++) begin
         ld_addr = AW'(8'h80 + e);
         ld_data = DW'(16'h8000 + e);
         model[ld_addr] = ld_data;
         for (int i = 0; i < 3; i++)
            chk($sformatf("avail_under_load_l%0d_e%0d", LAT[i], e), 32'(avail[i]), 32'(n < 4));
         rd_valid = 1'b1;
         rd_addr  = AW'(8'h40 + n);
         acc = avail[0];
         tick();
         if (acc) begin
            exp_data.push_back(model[AW'(8'h40 + n)]);
            exp_cyc.push_back(-1);
            n++;
         end
      end
      ld_valid = 1'b0;
      rd_valid = 1'b0;
      no_pulse_win = 1'b0;
      chk("accepted_under_load", n, 4);
      fetch(8'h44, -1, w);
      chk("refill_wait_first", w, 1);
      fetch(8'h45, -1, w);
      chk("refill_wait_second", w, 0);
      drain();

      // Load and queued read of the same address at one edge
      load(8'h20, 16'h1111);
      tick();
      ld_valid = 1'b1;
      ld_addr  = 8'h20;
      ld_data  = 16'h2222;
      model[8'h20] = 16'h2222;
      fetch(8'h20, 1, w);
      ld_valid = 1'b0;
      chk("race_wait", w, 0);
      drain();

      // Reset with three queued and one in flight
      ld_valid = 1'b1;
      for (int e = 0; e < 3; e++) begin
         ld_addr = AW'(8'h90 + e);
         ld_data = DW'(16'h9000 + e);
         model[ld_addr] = ld_data;
         fetch(AW'(e), -1, w);
      end
      ld_valid = 1'b0;
      fetch(8'h03, -1, w);
      for (int i = 0; i < 3; i++)
         chk($sformatf("busy_prereset_l%0d", LAT[i]), 32'(busy[i]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (8) tick();
      for (int i = 0; i < 3; i++)
         chk($sformatf("busy_after_reset_l%0d", LAT[i]), 32'(busy[i]), 32'd0);
      fetch(8'h10, 0, w);
      chk("post_reset_wait", w, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
